// File: rtl/mux_arbiter_if.sv
// Handshake bundle between the requester units and the shared-mux arbiter.
// The arbiter side connects through the master modport, requesters through slave.
interface mux_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_LINES = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   grant;
    logic [SEL_LINES-1:0] sel;
    logic                 busy;
    logic                 expired;

    // Arbiter: samples requests, drives grant/select/status.
    modport master (
        input  req,
        output grant,
        output sel,
        output busy,
        output expired
    );

    // Requester side: raises requests, observes grant/select/status.
    modport slave (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  expired
    );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a shared 4-way datapath mux.
// One owner at a time, one mandatory idle (turnaround) cycle between tenures,
// and an optional cap on tenure length so a single requester cannot starve
// the others. All outputs are registered.
module mux_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_LINES = 2,
    parameter int MAX_HOLD  = 8,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arbiter_if.master bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Tenure limit bookkeeping; a zero limit means tenures are unbounded.
    localparam bit                   HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0]     LIMIT_M1     = (MAX_HOLD == 0) ? {CNT_W{1'b0}}
                                                                    : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX      = {CNT_W{1'b1}};
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [SEL_LINES-1:0] PTR_RST      = SEL_LINES'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [SEL_LINES-1:0] sel_q,   sel_d;
    logic                 busy_q,  busy_d;
    logic                 expired_q, expired_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [SEL_LINES-1:0] ptr_q,   ptr_d;

    logic [SEL_LINES:0]   pick_s;
    logic                 owner_req_s;

    // Round-robin search: first set request scanning ptr+1 .. ptr (mod NUM_REQ).
    // Returns {found, index}. Scanning from the lowest priority upward lets the
    // last hit (the highest priority one) win.
    function automatic logic [SEL_LINES:0] rr_pick(input logic [NUM_REQ-1:0]   r,
                                                   input logic [SEL_LINES-1:0] p);
        logic [SEL_LINES:0]   res;
        logic [SEL_LINES-1:0] idx;
        res = {(SEL_LINES + 1){1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = SEL_LINES'((int'(p) + k) % NUM_REQ);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_LINES-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = {NUM_REQ{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    assign pick_s      = rr_pick(bus.req, ptr_q);
    assign owner_req_s = bus.req[sel_q];

    // Next-state and registered-output logic for the IDLE/GRANT arbiter.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        expired_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_s[SEL_LINES]) begin
                    state_d = ST_GRANT;
                    grant_d = onehot(pick_s[SEL_LINES-1:0]);
                    sel_d   = pick_s[SEL_LINES-1:0];
                    busy_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    // Nobody asking: stay parked, select keeps the last owner.
                    grant_d = {NUM_REQ{1'b0}};
                    busy_d  = 1'b0;
                end
            end

            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Voluntary release wins even when the limit is reached.
                    state_d = ST_IDLE;
                    grant_d = {NUM_REQ{1'b0}};
                    busy_d  = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    ptr_d   = sel_q;
                end else if (HOLD_LIMITED && (cnt_q == LIMIT_M1)) begin
                    // Tenure cap reached: preempt and flag it for one cycle.
                    state_d   = ST_IDLE;
                    grant_d   = {NUM_REQ{1'b0}};
                    busy_d    = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    ptr_d     = sel_q;
                    expired_d = 1'b1;
                end else begin
                    // Owner keeps the mux; count saturates so unlimited mode never wraps.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= {NUM_REQ{1'b0}};
            sel_q     <= {SEL_LINES{1'b0}};
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: three instances with tenure limits 2, 8 and unlimited.
// Each scenario task drives requests at the falling edge, pushes the expected
// registered outputs into a scoreboard queue, and pops/compares them 1 time
// unit after the following rising edge.
module tb_mux_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // 10-unit clock period.
    always #5 clk = ~clk;

    mux_arbiter_if if2 ();
    mux_arbiter_if if8 ();
    mux_arbiter_if if0 ();

    mux_arbiter #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
    mux_arbiter #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.master));
    mux_arbiter #(.MAX_HOLD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       expired;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    // Reset values on all instances, then the first grant one edge after release.
    task automatic test_reset();
        exp_t e;
        exp_t got;
        rst_n   = 1'b0;
        if2.req = 4'b1111;
        if8.req = 4'b0000;
        if0.req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        got = {if2.grant, if2.sel, if2.busy, if2.expired};
        checks_total++;
        if (got !== 8'h00) $display("FAIL reset_dut2: got %b, expected 00000000", got);
        else checks_passed++;
        got = {if8.grant, if8.sel, if8.busy, if8.expired};
        checks_total++;
        if (got !== 8'h00) $display("FAIL reset_dut8: got %b, expected 00000000", got);
        else checks_passed++;
        got = {if0.grant, if0.sel, if0.busy, if0.expired};
        checks_total++;
        if (got !== 8'h00) $display("FAIL reset_dut0: got %b, expected 00000000", got);
        else checks_passed++;

        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back({4'b0001, 2'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {if2.grant, if2.sel, if2.busy, if2.expired};
        checks_total++;
        if (got !== e) $display("FAIL reset_first_grant: got %b, expected %b", got, e);
        else checks_passed++;
    endtask

    // MAX_HOLD=2, all four requesting: two grant cycles, one expired idle, next owner.
    task automatic test_round_robin();
        logic [11:0] tbl[$];
        logic [3:0]  g;
        int          n;
        for (int r = 0; r < 5; r++) begin
            g = 4'b0001 << (r % 4);
            n = (r == 0) ? 1 : 2;
            for (int c = 0; c < n; c++) tbl.push_back({4'b1111, g, 2'(r % 4), 1'b1, 1'b0});
            tbl.push_back({4'b1111, 4'b0000, 2'(r % 4), 1'b0, 1'b1});
        end
        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            if2.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if2.grant, if2.sel, if2.busy, if2.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL round_robin step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end
        @(negedge clk);
        if2.req = 4'b0000;
    endtask

    // Voluntary release leaves expired low and moves the pointer to the owner.
    task automatic test_voluntary_release();
        logic [11:0] tbl[$];
        for (int c = 0; c < 3; c++) tbl.push_back({4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
        tbl.push_back({4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0});
        // Pointer now 0, so requester 2 beats requester 0.
        tbl.push_back({4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            if8.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if8.grant, if8.sel, if8.busy, if8.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL voluntary step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end
    endtask

    // Sole requester with MAX_HOLD=8: 8 grant cycles, expired idle, re-grant.
    task automatic test_sole_preempt();
        logic [11:0] tbl[$];
        for (int c = 0; c < 8; c++) tbl.push_back({4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        tbl.push_back({4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1});
        tbl.push_back({4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        tbl.push_back({4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            if8.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if8.grant, if8.sel, if8.busy, if8.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL sole_preempt step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end
    endtask

    // Owner drops req exactly when the limit is reached: voluntary, no expired pulse.
    task automatic test_limit_tie();
        logic [11:0] tbl[$];
        for (int c = 0; c < 8; c++) tbl.push_back({4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            if8.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if8.grant, if8.sel, if8.busy, if8.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL limit_tie step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end
    endtask

    // MAX_HOLD=0: 300-cycle tenure (past counter saturation), then hand-over.
    task automatic test_unlimited_hold();
        logic [11:0] tbl[$];
        for (int c = 0; c < 300; c++) tbl.push_back({4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0});
        tbl.push_back({4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0});
        tbl.push_back({4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        tbl.push_back({4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            if0.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if0.grant, if0.sel, if0.busy, if0.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL unlimited step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end
    endtask

    // Reset between edges mid-tenure clears outputs at once; pointer restarts at 3.
    task automatic test_async_reset();
        logic [11:0] tbl[$];
        exp_t        e;
        exp_t        got;
        // Pointer is 1 here (last owner), counter reaches 5 after six grant cycles.
        for (int c = 0; c < 6; c++) tbl.push_back({4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0});
        foreach (tbl[i]) begin
            @(negedge clk);
            if8.req = tbl[i][11:8];
            sb_q.push_back(tbl[i][7:0]);
            @(posedge clk);
            #1;
            e   = sb_q.pop_front();
            got = {if8.grant, if8.sel, if8.busy, if8.expired};
            checks_total++;
            if (got !== e)
                $display("FAIL async_pre step %0d: got grant=%b sel=%0d busy=%b expired=%b, expected grant=%b sel=%0d busy=%b expired=%b",
                         i, got.grant, got.sel, got.busy, got.expired, e.grant, e.sel, e.busy, e.expired);
            else checks_passed++;
        end

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {if8.grant, if8.sel, if8.busy, if8.expired};
        checks_total++;
        if (got !== 8'h00) $display("FAIL async_clear: got %b, expected 00000000", got);
        else checks_passed++;

        // With pointer 3, requester 1 beats 3; a retained pointer of 1 would pick 3.
        @(negedge clk);
        if8.req = 4'b1010;
        rst_n   = 1'b1;
        sb_q.push_back({4'b0010, 2'd1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {if8.grant, if8.sel, if8.busy, if8.expired};
        checks_total++;
        if (got !== e) $display("FAIL async_regrant: got %b, expected %b", got, e);
        else checks_passed++;

        @(negedge clk);
        if8.req = 4'b0000;
        sb_q.push_back({4'b0000, 2'd1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {if8.grant, if8.sel, if8.busy, if8.expired};
        checks_total++;
        if (got !== e) $display("FAIL async_release: got %b, expected %b", got, e);
        else checks_passed++;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_round_robin();
        test_voluntary_release();
        test_sole_preempt();
        test_limit_tie();
        test_unlimited_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
